// File: rtl/matrix_code_pkg.sv
// Shared constants and check equations for the light-ABFT matrix-code row scheme.
// Used by the row encoder and the row decoder.
package matrix_code_pkg;

  localparam int ROW_WORDS = 4;
  localparam int CHK_WORDS = 3;

  // One bit lane of the row checks; the checks are pure XOR,
  // so applying this to every bit of the words gives {z11, z12, z13}.
  function automatic logic [CHK_WORDS-1:0] mc_row_checks(
    input logic p11,
    input logic p12,
    input logic p13,
    input logic p14
  );
    mc_row_checks = {
      p11 ^ p12 ^ p13,
      p11 ^ p12 ^ p14,
      p11 ^ p13 ^ p14
    };
  endfunction

endpackage

// File: rtl/matrix_code_chk_gen.sv
// Combinational check-word generator for one 4-word row.
// Ports: p11..p14 data words in, z11..z13 check words out (all DW wide).
module matrix_code_chk_gen
  import matrix_code_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] p11,
  input  logic [DW-1:0] p12,
  input  logic [DW-1:0] p13,
  input  logic [DW-1:0] p14,
  output logic [DW-1:0] z11,
  output logic [DW-1:0] z12,
  output logic [DW-1:0] z13
);

  for (genvar b = 0; b < DW; b++) begin : g_lane
    logic [CHK_WORDS-1:0] z;
    assign z = mc_row_checks(p11[b], p12[b], p13[b], p14[b]);
    assign z11[b] = z[2];
    assign z12[b] = z[1];
    assign z13[b] = z[0];
  end

endmodule

// File: rtl/matrix_code_row_enc.sv
// Streaming matrix-code row encoder: packs 4 input words into a row plus 3 checks.
// Ports: in_* valid/ready word stream, out_* registered row beat, row_count, busy.
module matrix_code_row_enc
  import matrix_code_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_p11,
  output logic [DW-1:0]    out_p12,
  output logic [DW-1:0]    out_p13,
  output logic [DW-1:0]    out_p14,
  output logic [DW-1:0]    out_z11,
  output logic [DW-1:0]    out_z12,
  output logic [DW-1:0]    out_z13,
  output logic [CNT_W-1:0] row_count,
  output logic             busy
);

  localparam logic [1:0] LAST = 2'(ROW_WORDS - 1);

  logic [1:0]    cnt;
  logic [DW-1:0] s0, s1, s2;
  logic [DW-1:0] z11, z12, z13;
  logic          in_fire;
  logic          out_fire;
  logic          load;

  // Only the row-completing word waits for the output register.
  assign in_ready = (cnt != LAST) || !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign load     = in_fire && (cnt == LAST);
  assign busy     = (cnt != 2'd0);

  matrix_code_chk_gen #(
    .DW(DW)
  ) u_chk (
    .p11(s0),
    .p12(s1),
    .p13(s2),
    .p14(in_data),
    .z11(z11),
    .z12(z12),
    .z13(z13)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      s0        <= '0;
      s1        <= '0;
      s2        <= '0;
      out_valid <= 1'b0;
      out_p11   <= '0;
      out_p12   <= '0;
      out_p13   <= '0;
      out_p14   <= '0;
      out_z11   <= '0;
      out_z12   <= '0;
      out_z13   <= '0;
      row_count <= '0;
    end else begin
      if (in_fire) begin
        unique case (cnt)
          2'd0:    s0 <= in_data;
          2'd1:    s1 <= in_data;
          2'd2:    s2 <= in_data;
          default: ;
        endcase
        cnt <= cnt + 2'd1;
      end
      // A load on the same edge as an output transfer keeps
      // out_valid high, giving bubble-free back-to-back rows.
      if (load) begin
        out_valid <= 1'b1;
        out_p11   <= s0;
        out_p12   <= s1;
        out_p13   <= s2;
        out_p14   <= in_data;
        out_z11   <= z11;
        out_z12   <= z12;
        out_z13   <= z13;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      if (out_fire) begin
        row_count <= row_count + 1'b1;
      end
    end
  end

endmodule
